// File: rtl/vga_frame_capture.sv
// rtl/vga_frame_capture.sv - VGA sync decoder capturing one frame to a write port; VGA_CAPTURE_CRC_EN adds a frame CRC-16
module vga_frame_capture #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    input  logic [7:0]        red,
    input  logic [7:0]        green,
    input  logic [7:0]        blue,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              start,
    output logic              busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    output logic              frame_done,
    output logic              timing_err,
    output logic [15:0]       crc
);
    localparam int H_TOTAL = H_FP + H_SYNC + H_BP + H_ACTIVE;
    localparam int V_TOTAL = V_FP + V_SYNC + V_BP + V_ACTIVE;
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    typedef enum logic [1:0] {IDLE, SEEK, CAPTURE, DONE} state_t;

    state_t              state_q, state_d;
    logic [HW-1:0]       hcnt_q, hcnt_d;
    logic [VW-1:0]       vcnt_q, vcnt_d;
    logic                hs_q, hs_d, vs_q, vs_d;
    logic                first_hs_q, first_hs_d;
    logic                busy_q, busy_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [23:0]         wr_data_q, wr_data_d;
    logic                frame_done_q, frame_done_d;
    logic                timing_err_q, timing_err_d;
    logic                hs_fall, vs_fall, active, last_pix, hs_bad, vs_bad;
    logic [HW-1:0]       x;
    logic [VW-1:0]       y;

    // Counters describe the sample being taken this edge, so a sync fall sample is position 0.
    always_comb begin
        hs_d    = hs_q;
        vs_d    = vs_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        hs_fall = 1'b0;
        vs_fall = 1'b0;
        if (pix_en) begin
            hs_d    = hsync;
            vs_d    = vsync;
            hs_fall = hs_q & ~hsync;
            vs_fall = vs_q & ~vsync;
            if (hs_fall)
                hcnt_d = '0;
            else if (hcnt_q != HW'(H_TOTAL))
                hcnt_d = hcnt_q + HW'(1);
            if (vs_fall)
                vcnt_d = '0;
            else if (hs_fall && vcnt_q != VW'(V_TOTAL))
                vcnt_d = vcnt_q + VW'(1);
        end
        x        = hcnt_d - HW'(H_START);
        y        = vcnt_d - VW'(V_START);
        active   = pix_en
                 && hcnt_d >= HW'(H_START) && hcnt_d < HW'(H_START + H_ACTIVE)
                 && vcnt_d >= VW'(V_START) && vcnt_d < VW'(V_START + V_ACTIVE);
        last_pix = (x == HW'(H_ACTIVE - 1)) && (y == VW'(V_ACTIVE - 1));
        hs_bad   = hs_fall && !first_hs_q && (hcnt_q != HW'(H_TOTAL - 1));
        vs_bad   = vs_fall && (vcnt_q != VW'(V_TOTAL - 1));
    end

    always_comb begin
        state_d      = state_q;
        first_hs_d   = first_hs_q;
        busy_d       = busy_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        timing_err_d = timing_err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = SEEK;
                    busy_d       = 1'b1;
                    timing_err_d = 1'b0;
                end
            end
            SEEK: begin
                if (vs_fall) begin
                    state_d    = CAPTURE;
                    first_hs_d = 1'b1;
                end
            end
            CAPTURE: begin
                if (hs_fall)
                    first_hs_d = 1'b0;
                if (hs_bad || vs_bad) begin
                    timing_err_d = 1'b1;
                    state_d      = SEEK;
                end else if (active) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ADDR_W'(y) * ADDR_W'(H_ACTIVE) + ADDR_W'(x);
                    wr_data_d = {red, green, blue};
                    if (last_pix)
                        state_d = DONE;
                end
            end
            DONE: begin
                frame_done_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            first_hs_q   <= 1'b0;
            busy_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            timing_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            first_hs_q   <= first_hs_d;
            busy_q       <= busy_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            timing_err_q <= timing_err_d;
        end
    end

    assign busy       = busy_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign timing_err = timing_err_q;

`ifdef VGA_CAPTURE_CRC_EN
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    logic [15:0] crc_q, crc_d;

    // Accumulates across a timing-error restart; only a new start reseeds it.
    always_comb begin
        crc_d = crc_q;
        if (state_q == IDLE && start)
            crc_d = 16'hFFFF;
        else if (wr_en_d)
            crc_d = crc16_byte(crc16_byte(crc16_byte(crc_q, wr_data_d[23:16]),
                                          wr_data_d[15:8]), wr_data_d[7:0]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            crc_q <= '0;
        else
            crc_q <= crc_d;
    end

    assign crc = crc_q;
`else
    assign crc = 16'h0000;
`endif
endmodule

// File: tb/tb_vga_frame_capture.sv
// tb/tb_vga_frame_capture.sv - directed bench for vga_frame_capture on an 8x4 test timing
module tb_vga_frame_capture;
    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en;
    logic [7:0]  red, green, blue;
    logic        hsync, vsync, start;
    logic        busy, wr_en, frame_done, timing_err;
    logic [4:0]  wr_addr;
    logic [23:0] wr_data;
    logic [15:0] crc;

    int          nvec = 0;
    int          nerr = 0;
    logic [15:0] mcrc;
    bit          armed, exp_terr, fd_exp;

    vga_frame_capture #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .ADDR_W(5)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .start(start),
        .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .timing_err(timing_err), .crc(crc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_model(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in ^ {d, 8'h00};
        repeat (8) c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        return c;
    endfunction

    function automatic logic [15:0] exp_crc();
`ifdef VGA_CAPTURE_CRC_EN
        return mcrc;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic tick(input bit ew, input int ea, input logic [23:0] ed);
        @(posedge clk);
        #1;
        chk("wr_en", 32'(wr_en), 32'(ew));
        if (ew) begin
            chk("wr_addr", 32'(wr_addr), 32'(ea));
            chk("wr_data", 32'(wr_data), 32'(ed));
            mcrc = crc_model(crc_model(crc_model(mcrc, ed[23:16]), ed[15:8]), ed[7:0]);
            chk("crc_on_write", 32'(crc), 32'(exp_crc()));
        end
        chk("frame_done", 32'(frame_done), 32'(fd_exp));
        if (fd_exp) begin
            armed = 1'b0;
            chk("busy_at_done", 32'(busy), 32'(0));
            chk("crc_at_done", 32'(crc), 32'(exp_crc()));
        end
        fd_exp = ew && (ea == 31);
    endtask

    task automatic arm_model();
        if (!armed) begin
            armed    = 1'b1;
            mcrc     = 16'hFFFF;
            exp_terr = 1'b0;
        end
    endtask

    task automatic end_checks(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'(armed));
        chk({tag, "_timing_err"}, 32'(timing_err), 32'(exp_terr));
        chk({tag, "_crc"}, 32'(crc), 32'(exp_crc()));
    endtask

    task automatic start_pulse();
        pix_en = 1'b0;
        start  = 1'b1;
        arm_model();
        tick(1'b0, 0, 24'h0);
        start = 1'b0;
        end_checks("after_start");
    endtask

    task automatic reset_abort();
        #1 reset = 1'b1;
        #1;
        chk("abort_wr_en", 32'(wr_en), 32'(0));
        chk("abort_wr_addr", 32'(wr_addr), 32'(0));
        chk("abort_wr_data", 32'(wr_data), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_frame_done", 32'(frame_done), 32'(0));
        chk("abort_timing_err", 32'(timing_err), 32'(0));
        chk("abort_crc", 32'(crc), 32'(0));
        pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1;
        #1 reset = 1'b0;
        armed = 1'b0; fd_exp = 1'b0; exp_terr = 1'b0; mcrc = 16'h0000;
    endtask

    // One frame: line 0 carries vsync, samples 0-1 of every line carry hsync.
    task automatic send_frame(input bit cap, input bit half, input int short_line,
                              input int start_line, input int abort_addr, input bit zero);
        int          addr, hlen;
        bit          act, ew, aborted;
        logic [7:0]  x, y;
        logic [23:0] px;
        addr    = 0;
        aborted = 1'b0;
        for (int v = 0; v < 7 && !aborted; v++) begin
            hlen = (v == short_line) ? 13 : 14;
            for (int h = 0; h < hlen && !aborted; h++) begin
                act = (v >= 2) && (v < 6) && (h >= 4) && (h < 12);
                ew  = cap && act && (short_line < 0 || v <= short_line);
                x   = 8'(h - 4);
                y   = 8'(v - 2);
                px  = (act && !zero) ? {x, y, 8'h5A} : 24'h0;
                pix_en = 1'b1;
                hsync  = (h >= 2);
                vsync  = (v >= 1);
                {red, green, blue} = px;
                start  = (v == start_line) && (h == 0);
                if (start) arm_model();
                tick(ew, addr, px);
                start = 1'b0;
                if (ew) begin
                    if (addr == abort_addr) begin
                        reset_abort();
                        aborted = 1'b1;
                    end
                    addr++;
                end
                if (half && !aborted) begin
                    pix_en = 1'b0;
                    {red, green, blue} = 24'($urandom);
                    hsync = ~hsync;
                    vsync = ~vsync;
                    tick(1'b0, 0, 24'h0);
                end
            end
        end
        pix_en = 1'b0;
        hsync  = 1'b1;
        vsync  = 1'b1;
    endtask

    initial begin
        logic [15:0] zc;
        reset = 1'b1; pix_en = 1'b0; start = 1'b0;
        red = 8'h0; green = 8'h0; blue = 8'h0; hsync = 1'b1; vsync = 1'b1;
        mcrc = 16'h0000; armed = 1'b0; exp_terr = 1'b0; fd_exp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'(0));
        chk("rst_wr_addr", 32'(wr_addr), 32'(0));
        chk("rst_wr_data", 32'(wr_data), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_frame_done", 32'(frame_done), 32'(0));
        chk("rst_timing_err", 32'(timing_err), 32'(0));
        chk("rst_crc", 32'(crc), 32'(0));
        @(negedge clk) reset = 1'b0;

        send_frame(1'b0, 1'b0, -1, -1, -1, 1'b0);
        end_checks("idle_frame");

        start_pulse();
        send_frame(1'b1, 1'b0, -1, -1, -1, 1'b0);
        end_checks("clean_frame");

        start_pulse();
        send_frame(1'b1, 1'b1, -1, -1, -1, 1'b0);
        end_checks("half_rate");

        start_pulse();
        send_frame(1'b1, 1'b0, 3, -1, -1, 1'b0);
        exp_terr = 1'b1;
        end_checks("short_line");
        send_frame(1'b1, 1'b0, -1, -1, -1, 1'b0);
        end_checks("after_violation");

        send_frame(1'b0, 1'b0, -1, 3, -1, 1'b0);
        end_checks("start_mid_frame");
        send_frame(1'b1, 1'b0, -1, 4, -1, 1'b0);
        end_checks("start_while_busy");

        start_pulse();
        send_frame(1'b1, 1'b0, -1, -1, 10, 1'b0);
        end_checks("after_abort");
        start_pulse();
        send_frame(1'b1, 1'b0, -1, -1, -1, 1'b0);
        end_checks("post_abort_frame");

        start_pulse();
        send_frame(1'b1, 1'b0, -1, -1, -1, 1'b1);
        end_checks("zero_frame");
        zc = 16'hFFFF;
        repeat (96) zc = crc_model(zc, 8'h00);
`ifdef VGA_CAPTURE_CRC_EN
        chk("crc_96_zero_bytes", 32'(crc), 32'(zc));
`else
        chk("crc_disabled", 32'(crc), 32'(0));
`endif
        repeat (3) tick(1'b0, 0, 24'h0);
        chk("crc_hold", 32'(crc), 32'(exp_crc()));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/vga_frame_capture.md
Name: vga_frame_capture

Overview:
- Receive-side counterpart of the processor's VGA output (red/green/blue/hsync/vsync).
- Decodes sync timing, recovers pixel coordinates and writes one captured frame into a memory write port for bench and on-chip checking.
- Flags sync-timing violations and optionally produces a per-frame CRC for golden-frame comparison.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- ADDR_W, 19, write address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel-rate enable; sync/RGB are sampled only when high
- red  in  8  pixel red
- green  in  8  pixel green
- blue  in  8  pixel blue
- hsync  in  1  horizontal sync, active low
- vsync  in  1  vertical sync, active low
- start  in  1  one-cycle pulse; arms capture of the next complete frame
- busy  out  1  high from start until frame done or abort
- wr_en  out  1  one-cycle pixel write strobe
- wr_addr  out  ADDR_W  y*H_ACTIVE + x
- wr_data  out  24  {red, green, blue}
- frame_done  out  1  one-cycle pulse after the last pixel write
- timing_err  out  1  sticky sync-timing violation flag
- crc  out  16  frame CRC, valid at frame_done (see Optional Feature)

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, sync history registers 1 (deasserted).
- Sampling:
  - On every clk edge with pix_en=1, register red/green/blue/hsync/vsync.
  - A falling edge is previous sample 1 and current sample 0, both taken on pix_en cycles.
- hcnt:
  - Cleared to 0 on an hsync falling edge; otherwise increments on each pix_en sample.
  - Saturates at H_TOTAL = H_FP+H_SYNC+H_BP+H_ACTIVE.
- vcnt:
  - Increments on each hsync fall.
  - Cleared to 0 on a vsync fall; the clear wins over the increment when both occur on the same sample.
  - Saturates at V_TOTAL.
- Active pixel:
  - hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
  - x = hcnt-(H_SYNC+H_BP), y = vcnt-(V_SYNC+V_BP).
- States:
  - IDLE: start -> SEEK. busy=1; timing_err and CRC cleared.
  - SEEK: wait for a vsync fall -> CAPTURE. No writes.
  - CAPTURE: each active pixel sample gives wr_en=1 with wr_addr/wr_data on the next clk cycle, lasting one cycle.
  - CAPTURE exit: after the write for x=H_ACTIVE-1, y=V_ACTIVE-1 -> DONE.
  - DONE: frame_done=1 and busy=0 for one cycle -> IDLE.
- Latency: pix_en sample edge to wr_en assertion is exactly one clk.
  - Exactly H_ACTIVE*V_ACTIVE writes per capture, addresses strictly sequential from 0.
- Timing check, in CAPTURE only:
  - An hsync fall with hcnt != H_TOTAL-1, or a vsync fall with vcnt != V_TOTAL-1, is a violation.
  - The first hsync fall after entering CAPTURE is exempt from the hcnt check.
  - On a violation: set timing_err (sticky until the next start) and return to SEEK. Addresses restart at 0 on the next vsync fall; busy stays 1.
- start while busy: ignored.
- reset mid-frame: immediate return to reset values; any partial frame is discarded with no frame_done.
- pix_en=0: the module holds all state; wr_en and frame_done are never asserted due to an un-enabled cycle.

Optional Feature:
- Macro: VGA_CAPTURE_CRC_EN.
- Defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection, no final XOR) over the wr_data bytes red, green, blue of each written pixel, in write order.
  - crc is updated in the same cycle as wr_en and holds its final value from frame_done until the next start.
- Undefined: crc is constant 0 and no CRC logic is synthesized.

Test Plan:
- Small timing (H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1), clean frames, RGB = {x, y, 0x5A}, start pulse -> 32 writes, wr_addr 0..31 in order, wr_data[23:16]=x, frame_done once, timing_err=0.
- Same setup, pix_en high one cycle in two -> identical 32 writes, each wr_en one clk after its pix_en edge.
- A line shortened to 13 pixels mid-capture -> timing_err=1 and return to SEEK; the next clean frame gives 32 writes from addr 0, then frame_done; timing_err stays 1 until the next start.
- start asserted mid-frame -> no writes until the next vsync fall; start again while busy -> no effect.
- reset asserted after write 10 -> all outputs 0 immediately; after release and a new start, a full 32-write frame.
- With VGA_CAPTURE_CRC_EN, all pixels 0x000000 -> crc equals the CRC-16-CCITT of 96 zero bytes, matching the bench model; with the macro undefined, crc=0.
